// File: rtl/valu_wb_collector.sv
// Writeback collector for the vector ALU: buffers result beats in a small FIFO,
// drains them into the scalar/vector RF write ports and clears scoreboard entries.
module valu_wb_collector #(
  parameter int DATA_W     = 128,
  parameter int FIFO_DEPTH = 4
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              alu_wb_valid,
  input  logic [4:0]        alu_wb_rd,
  input  logic              alu_wb_is_scalar,
  input  logic [DATA_W-1:0] alu_wb_data,
  input  logic              alu_wb_err_overflow,
  input  logic              alu_wb_err_invalid,
  output logic              issue_stall,
  output logic              vrf_we,
  output logic [4:0]        vrf_waddr,
  output logic [DATA_W-1:0] vrf_wdata,
  input  logic              vrf_wready,
  output logic              srf_we,
  output logic [4:0]        srf_waddr,
  output logic [31:0]       srf_wdata,
  input  logic              srf_wready,
  output logic              sb_clr_valid,
  output logic [4:0]        sb_clr_idx,
  output logic              sb_clr_is_scalar,
  output logic              fflags_of,
  output logic              fflags_nv,
  input  logic              fflags_clr,
  output logic              fifo_ovf_err,
  output logic              idle
);

  localparam int PW = (FIFO_DEPTH > 2) ? $clog2(FIFO_DEPTH) : 1;
  localparam int CW = $clog2(FIFO_DEPTH + 1);

  logic [4:0]        rd_mem   [FIFO_DEPTH];
  logic              sc_mem   [FIFO_DEPTH];
  logic [DATA_W-1:0] data_mem [FIFO_DEPTH];

  logic [PW-1:0] head_ptr;
  logic [PW-1:0] tail_ptr;
  logic [CW-1:0] count;

  logic              empty;
  logic [4:0]        head_rd;
  logic              head_sc;
  logic [DATA_W-1:0] head_data;
  logic              head_x0;
  logic              wr_accept;
  logic              pop;
  logic              push_ok;

  assign empty     = (count == '0);
  assign head_rd   = rd_mem[head_ptr];
  assign head_sc   = sc_mem[head_ptr];
  assign head_data = data_mem[head_ptr];

  // Writes to scalar x0 are architecturally dead, so they retire silently.
  assign head_x0 = !empty && head_sc && (head_rd == 5'd0);

  assign vrf_we    = !empty && !head_sc;
  assign vrf_waddr = head_rd;
  assign vrf_wdata = head_data;
  assign srf_we    = !empty && head_sc && (head_rd != 5'd0);
  assign srf_waddr = head_rd;
  assign srf_wdata = head_data[31:0];

  assign wr_accept = (vrf_we && vrf_wready) || (srf_we && srf_wready);
  assign pop       = wr_accept || head_x0;
  assign push_ok   = alu_wb_valid && ((count < CW'(FIFO_DEPTH)) || pop);

  assign sb_clr_valid     = wr_accept;
  assign sb_clr_idx       = head_rd;
  assign sb_clr_is_scalar = head_sc;

  // One slot stays free for the op already inside the ALU pipeline.
  assign issue_stall = (count >= CW'(FIFO_DEPTH - 1));
  assign idle        = empty && !alu_wb_valid;

  always_ff @(posedge clk) begin
    if (rst) begin
      head_ptr     <= '0;
      tail_ptr     <= '0;
      count        <= '0;
      fflags_of    <= 1'b0;
      fflags_nv    <= 1'b0;
      fifo_ovf_err <= 1'b0;
    end else begin
      if (push_ok) tail_ptr <= tail_ptr + PW'(1);
      if (pop) head_ptr <= head_ptr + PW'(1);
      count <= count + CW'(push_ok) - CW'(pop);
      if (alu_wb_valid && !push_ok) fifo_ovf_err <= 1'b1;
      // A new exception outranks a simultaneous clear so no event is lost.
      if (alu_wb_valid && alu_wb_err_overflow) fflags_of <= 1'b1;
      else if (fflags_clr) fflags_of <= 1'b0;
      if (alu_wb_valid && alu_wb_err_invalid) fflags_nv <= 1'b1;
      else if (fflags_clr) fflags_nv <= 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (push_ok) begin
      rd_mem[tail_ptr]   <= alu_wb_rd;
      sc_mem[tail_ptr]   <= alu_wb_is_scalar;
      data_mem[tail_ptr] <= alu_wb_data;
    end
  end

endmodule

// File: tb/tb_valu_wb_collector.sv
// Directed bench for valu_wb_collector: each task drives one scenario and
// compares outputs against hand-computed values.
module tb_valu_wb_collector;

  logic         clk = 1'b0;
  logic         rst = 1'b1;
  logic         alu_wb_valid = 1'b0;
  logic [4:0]   alu_wb_rd = '0;
  logic         alu_wb_is_scalar = 1'b0;
  logic [127:0] alu_wb_data = '0;
  logic         alu_wb_err_overflow = 1'b0;
  logic         alu_wb_err_invalid = 1'b0;
  logic         issue_stall;
  logic         vrf_we;
  logic [4:0]   vrf_waddr;
  logic [127:0] vrf_wdata;
  logic         vrf_wready = 1'b0;
  logic         srf_we;
  logic [4:0]   srf_waddr;
  logic [31:0]  srf_wdata;
  logic         srf_wready = 1'b0;
  logic         sb_clr_valid;
  logic [4:0]   sb_clr_idx;
  logic         sb_clr_is_scalar;
  logic         fflags_of;
  logic         fflags_nv;
  logic         fflags_clr = 1'b0;
  logic         fifo_ovf_err;
  logic         idle;

  int n_vec = 0;
  int n_err = 0;

  valu_wb_collector #(.DATA_W(128), .FIFO_DEPTH(4)) dut (
    .clk(clk), .rst(rst),
    .alu_wb_valid(alu_wb_valid), .alu_wb_rd(alu_wb_rd),
    .alu_wb_is_scalar(alu_wb_is_scalar), .alu_wb_data(alu_wb_data),
    .alu_wb_err_overflow(alu_wb_err_overflow), .alu_wb_err_invalid(alu_wb_err_invalid),
    .issue_stall(issue_stall),
    .vrf_we(vrf_we), .vrf_waddr(vrf_waddr), .vrf_wdata(vrf_wdata), .vrf_wready(vrf_wready),
    .srf_we(srf_we), .srf_waddr(srf_waddr), .srf_wdata(srf_wdata), .srf_wready(srf_wready),
    .sb_clr_valid(sb_clr_valid), .sb_clr_idx(sb_clr_idx), .sb_clr_is_scalar(sb_clr_is_scalar),
    .fflags_of(fflags_of), .fflags_nv(fflags_nv), .fflags_clr(fflags_clr),
    .fifo_ovf_err(fifo_ovf_err), .idle(idle)
  );

  always #5 clk = ~clk;

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic beat(input logic [4:0] rd, input logic sc, input logic [127:0] data);
    alu_wb_valid = 1'b1;
    alu_wb_rd = rd;
    alu_wb_is_scalar = sc;
    alu_wb_data = data;
  endtask

  task automatic no_beat();
    alu_wb_valid = 1'b0;
    alu_wb_err_overflow = 1'b0;
    alu_wb_err_invalid = 1'b0;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    step();
    step();
    rst = 1'b0;
    #1;
    n_vec++; if (vrf_we !== 1'b0) begin n_err++; $display("[TB] FAIL rst_vrf_we: got %b want 0", vrf_we); end
    n_vec++; if (srf_we !== 1'b0) begin n_err++; $display("[TB] FAIL rst_srf_we: got %b want 0", srf_we); end
    n_vec++; if (sb_clr_valid !== 1'b0) begin n_err++; $display("[TB] FAIL rst_sb_clr: got %b want 0", sb_clr_valid); end
    n_vec++; if (issue_stall !== 1'b0) begin n_err++; $display("[TB] FAIL rst_stall: got %b want 0", issue_stall); end
    n_vec++; if (idle !== 1'b1) begin n_err++; $display("[TB] FAIL rst_idle: got %b want 1", idle); end
    n_vec++; if ({fflags_of, fflags_nv, fifo_ovf_err} !== 3'b000) begin n_err++; $display("[TB] FAIL rst_flags: got %b want 000", {fflags_of, fflags_nv, fifo_ovf_err}); end
  endtask

  task automatic test_vector_beat();
    vrf_wready = 1'b1;
    beat(5'd5, 1'b0, 128'h1234);
    #1;
    n_vec++; if (idle !== 1'b0) begin n_err++; $display("[TB] FAIL vec_idle_in: got %b want 0", idle); end
    n_vec++; if (vrf_we !== 1'b0) begin n_err++; $display("[TB] FAIL vec_no_bypass: got %b want 0", vrf_we); end
    step();
    no_beat();
    #1;
    n_vec++; if (vrf_we !== 1'b1) begin n_err++; $display("[TB] FAIL vec_we: got %b want 1", vrf_we); end
    n_vec++; if (vrf_waddr !== 5'd5) begin n_err++; $display("[TB] FAIL vec_waddr: got %0d want 5", vrf_waddr); end
    n_vec++; if (vrf_wdata !== 128'h1234) begin n_err++; $display("[TB] FAIL vec_wdata: got %h want 1234", vrf_wdata); end
    n_vec++; if (srf_we !== 1'b0) begin n_err++; $display("[TB] FAIL vec_srf_we: got %b want 0", srf_we); end
    n_vec++; if ({sb_clr_valid, sb_clr_idx, sb_clr_is_scalar} !== {1'b1, 5'd5, 1'b0}) begin n_err++; $display("[TB] FAIL vec_sb_clr: got %b/%0d/%b want 1/5/0", sb_clr_valid, sb_clr_idx, sb_clr_is_scalar); end
    step();
    #1;
    n_vec++; if (idle !== 1'b1) begin n_err++; $display("[TB] FAIL vec_idle_after: got %b want 1", idle); end
    n_vec++; if (vrf_we !== 1'b0) begin n_err++; $display("[TB] FAIL vec_we_after: got %b want 0", vrf_we); end
    vrf_wready = 1'b0;
  endtask

  task automatic test_scalar_stall();
    srf_wready = 1'b0;
    beat(5'd3, 1'b1, {96'hA5A5_0000_FFFF_1111_2222_3333, 32'hDEADBEEF});
    step();
    no_beat();
    for (int i = 0; i < 3; i++) begin
      #1;
      n_vec++; if ({srf_we, srf_waddr, srf_wdata} !== {1'b1, 5'd3, 32'hDEADBEEF}) begin n_err++; $display("[TB] FAIL sc_hold%0d: got %b/%0d/%h want 1/3/deadbeef", i, srf_we, srf_waddr, srf_wdata); end
      n_vec++; if (sb_clr_valid !== 1'b0) begin n_err++; $display("[TB] FAIL sc_noclr%0d: got %b want 0", i, sb_clr_valid); end
      step();
    end
    srf_wready = 1'b1;
    #1;
    n_vec++; if ({srf_we, srf_waddr, srf_wdata} !== {1'b1, 5'd3, 32'hDEADBEEF}) begin n_err++; $display("[TB] FAIL sc_accept: got %b/%0d/%h want 1/3/deadbeef", srf_we, srf_waddr, srf_wdata); end
    n_vec++; if ({sb_clr_valid, sb_clr_idx, sb_clr_is_scalar} !== {1'b1, 5'd3, 1'b1}) begin n_err++; $display("[TB] FAIL sc_clr: got %b/%0d/%b want 1/3/1", sb_clr_valid, sb_clr_idx, sb_clr_is_scalar); end
    step();
    srf_wready = 1'b0;
    #1;
    n_vec++; if ({srf_we, sb_clr_valid, idle} !== 3'b001) begin n_err++; $display("[TB] FAIL sc_done: got we/clr/idle=%b want 001", {srf_we, sb_clr_valid, idle}); end
  endtask

  task automatic test_back_to_back();
    logic exp_stall;
    vrf_wready = 1'b0;
    srf_wready = 1'b0;
    for (int k = 1; k <= 4; k++) begin
      beat(5'(k), (k % 2) == 1, 128'(k) * 128'h1111);
      #1;
      exp_stall = (k == 4);
      n_vec++; if (issue_stall !== exp_stall) begin n_err++; $display("[TB] FAIL b2b_stall%0d: got %b want %b", k, issue_stall, exp_stall); end
      step();
    end
    no_beat();
    #1;
    n_vec++; if (issue_stall !== 1'b1) begin n_err++; $display("[TB] FAIL b2b_stall_full: got %b want 1", issue_stall); end
    n_vec++; if (fifo_ovf_err !== 1'b0) begin n_err++; $display("[TB] FAIL b2b_ovf: got %b want 0", fifo_ovf_err); end
    vrf_wready = 1'b1;
    srf_wready = 1'b1;
    for (int j = 1; j <= 4; j++) begin
      #1;
      if ((j % 2) == 1) begin
        n_vec++; if ({srf_we, vrf_we, srf_waddr, srf_wdata} !== {2'b10, 5'(j), 32'(j * 32'h1111)}) begin n_err++; $display("[TB] FAIL b2b_drain%0d: got s%b v%b a%0d d%h want scalar rd %0d", j, srf_we, vrf_we, srf_waddr, srf_wdata, j); end
      end else begin
        n_vec++; if ({srf_we, vrf_we, vrf_waddr, vrf_wdata} !== {2'b01, 5'(j), 128'(j) * 128'h1111}) begin n_err++; $display("[TB] FAIL b2b_drain%0d: got s%b v%b a%0d d%h want vector rd %0d", j, srf_we, vrf_we, vrf_waddr, vrf_wdata, j); end
      end
      n_vec++; if ({sb_clr_valid, sb_clr_idx} !== {1'b1, 5'(j)}) begin n_err++; $display("[TB] FAIL b2b_clr%0d: got %b/%0d want 1/%0d", j, sb_clr_valid, sb_clr_idx, j); end
      step();
    end
    #1;
    n_vec++; if (idle !== 1'b1) begin n_err++; $display("[TB] FAIL b2b_idle: got %b want 1", idle); end
    vrf_wready = 1'b0;
    srf_wready = 1'b0;
  endtask

  task automatic test_overflow();
    logic [4:0] got [8];
    int n;
    // Part 1: full FIFO with both RFs stalled drops the fifth beat.
    for (int k = 0; k < 4; k++) begin
      beat(5'(10 + k), 1'b0, 128'(k));
      step();
    end
    beat(5'd14, 1'b0, 128'hEE);
    #1;
    n_vec++; if (issue_stall !== 1'b1) begin n_err++; $display("[TB] FAIL ovf_stall: got %b want 1", issue_stall); end
    step();
    no_beat();
    #1;
    n_vec++; if (fifo_ovf_err !== 1'b1) begin n_err++; $display("[TB] FAIL ovf_err_set: got %b want 1", fifo_ovf_err); end
    vrf_wready = 1'b1;
    n = 0;
    for (int c = 0; c < 8; c++) begin
      #1;
      if (sb_clr_valid && n < 8) begin got[n] = sb_clr_idx; n++; end
      step();
    end
    n_vec++; if (n !== 4) begin n_err++; $display("[TB] FAIL ovf_drain_cnt: got %0d want 4", n); end
    for (int i = 0; i < 4 && i < n; i++) begin
      n_vec++; if (got[i] !== 5'(10 + i)) begin n_err++; $display("[TB] FAIL ovf_order%0d: got %0d want %0d", i, got[i], 10 + i); end
    end
    // Part 2: a pop in the same cycle makes room for the fifth beat.
    vrf_wready = 1'b0;
    rst = 1'b1;
    step();
    rst = 1'b0;
    #1;
    n_vec++; if (fifo_ovf_err !== 1'b0) begin n_err++; $display("[TB] FAIL ovf_err_rst: got %b want 0", fifo_ovf_err); end
    for (int k = 0; k < 4; k++) begin
      beat(5'(20 + k), 1'b0, 128'(k));
      step();
    end
    beat(5'd24, 1'b0, 128'hF0);
    vrf_wready = 1'b1;
    #1;
    n_vec++; if ({sb_clr_valid, sb_clr_idx} !== {1'b1, 5'd20}) begin n_err++; $display("[TB] FAIL ovf2_pop: got %b/%0d want 1/20", sb_clr_valid, sb_clr_idx); end
    step();
    no_beat();
    vrf_wready = 1'b0;
    #1;
    n_vec++; if (fifo_ovf_err !== 1'b0) begin n_err++; $display("[TB] FAIL ovf2_err: got %b want 0", fifo_ovf_err); end
    n_vec++; if (issue_stall !== 1'b1) begin n_err++; $display("[TB] FAIL ovf2_stall: got %b want 1", issue_stall); end
    vrf_wready = 1'b1;
    n = 0;
    for (int c = 0; c < 8; c++) begin
      #1;
      if (sb_clr_valid && n < 8) begin got[n] = sb_clr_idx; n++; end
      step();
    end
    n_vec++; if (n !== 4) begin n_err++; $display("[TB] FAIL ovf2_drain_cnt: got %0d want 4", n); end
    for (int i = 0; i < 4 && i < n; i++) begin
      n_vec++; if (got[i] !== 5'(21 + i)) begin n_err++; $display("[TB] FAIL ovf2_order%0d: got %0d want %0d", i, got[i], 21 + i); end
    end
    vrf_wready = 1'b0;
  endtask

  task automatic test_x0();
    beat(5'd0, 1'b1, 128'hABCD);
    step();
    no_beat();
    #1;
    n_vec++; if ({srf_we, vrf_we, sb_clr_valid} !== 3'b000) begin n_err++; $display("[TB] FAIL x0_quiet: got s/v/clr=%b want 000", {srf_we, vrf_we, sb_clr_valid}); end
    n_vec++; if (idle !== 1'b0) begin n_err++; $display("[TB] FAIL x0_held: got idle %b want 0", idle); end
    step();
    #1;
    n_vec++; if (idle !== 1'b1) begin n_err++; $display("[TB] FAIL x0_popped: got idle %b want 1", idle); end
  endtask

  task automatic test_fflags();
    beat(5'd0, 1'b1, '0);
    alu_wb_err_overflow = 1'b1;
    fflags_clr = 1'b1;
    step();
    no_beat();
    fflags_clr = 1'b0;
    #1;
    n_vec++; if ({fflags_of, fflags_nv} !== 2'b10) begin n_err++; $display("[TB] FAIL ff_set_wins: got of/nv=%b want 10", {fflags_of, fflags_nv}); end
    beat(5'd0, 1'b1, '0);
    alu_wb_err_invalid = 1'b1;
    step();
    no_beat();
    #1;
    n_vec++; if ({fflags_of, fflags_nv} !== 2'b11) begin n_err++; $display("[TB] FAIL ff_nv_set: got of/nv=%b want 11", {fflags_of, fflags_nv}); end
    fflags_clr = 1'b1;
    step();
    fflags_clr = 1'b0;
    #1;
    n_vec++; if ({fflags_of, fflags_nv} !== 2'b00) begin n_err++; $display("[TB] FAIL ff_clear: got of/nv=%b want 00", {fflags_of, fflags_nv}); end
    alu_wb_err_overflow = 1'b1;
    alu_wb_err_invalid = 1'b1;
    step();
    no_beat();
    #1;
    n_vec++; if ({fflags_of, fflags_nv} !== 2'b00) begin n_err++; $display("[TB] FAIL ff_no_valid: got of/nv=%b want 00", {fflags_of, fflags_nv}); end
  endtask

  task automatic test_reset_mid();
    int writes;
    vrf_wready = 1'b0;
    srf_wready = 1'b0;
    beat(5'd7, 1'b0, 128'h77);
    step();
    beat(5'd8, 1'b0, 128'h88);
    step();
    no_beat();
    #1;
    n_vec++; if ({vrf_we, vrf_waddr} !== {1'b1, 5'd7}) begin n_err++; $display("[TB] FAIL rmid_pending: got %b/%0d want 1/7", vrf_we, vrf_waddr); end
    rst = 1'b1;
    step();
    rst = 1'b0;
    vrf_wready = 1'b1;
    srf_wready = 1'b1;
    writes = 0;
    for (int c = 0; c < 4; c++) begin
      #1;
      if (vrf_we || srf_we || sb_clr_valid) writes++;
      step();
    end
    n_vec++; if (writes !== 0) begin n_err++; $display("[TB] FAIL rmid_writes: got %0d want 0", writes); end
    #1;
    n_vec++; if (idle !== 1'b1) begin n_err++; $display("[TB] FAIL rmid_idle: got %b want 1", idle); end
  endtask

  initial begin
    test_reset();
    test_vector_beat();
    test_scalar_stall();
    test_back_to_back();
    test_overflow();
    test_x0();
    test_fflags();
    test_reset_mid();
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule

// File: doc/valu_wb_collector.md
Name: valu_wb_collector

Overview:
Consumer end of the vector ALU writeback stream. It captures every writeback beat the ALU produces (rd, scalar/vector destination, data, FP error flags) into a small FIFO. It then drains each entry into the scalar or vector register-file write port under a valid/ready handshake and pulses a scoreboard-clear for that destination. Because the ALU has no output backpressure and one cycle of latency, the block also generates the issue-stall that keeps its FIFO from overflowing, and it keeps sticky FP exception flags.

Parameters:
DATA_W, 128, width of vector writeback data and vector RF write port
FIFO_DEPTH, 4, number of buffered writeback entries (power of two, >= 2)

Ports:
clk  input  1  clock, all state updates on rising edge
rst  input  1  synchronous active-high reset
alu_wb_valid  input  1  ALU writeback beat present this cycle
alu_wb_rd  input  5  destination register index
alu_wb_is_scalar  input  1  1 = scalar RF destination, 0 = vector RF
alu_wb_data  input  DATA_W  result data
alu_wb_err_overflow  input  1  FP overflow flag for this beat
alu_wb_err_invalid  input  1  FP invalid (NaN input) flag for this beat
issue_stall  output  1  issuer must not launch a new ALU op this cycle
vrf_we  output  1  vector RF write request
vrf_waddr  output  5  vector RF write index
vrf_wdata  output  DATA_W  vector RF write data
vrf_wready  input  1  vector RF accepts write this cycle
srf_we  output  1  scalar RF write request
srf_waddr  output  5  scalar RF write index
srf_wdata  output  32  scalar RF write data
srf_wready  input  1  scalar RF accepts write this cycle
sb_clr_valid  output  1  one-cycle pulse: destination write completed
sb_clr_idx  output  5  register index being cleared
sb_clr_is_scalar  output  1  scoreboard bank being cleared
fflags_of  output  1  sticky FP overflow
fflags_nv  output  1  sticky FP invalid
fflags_clr  input  1  clear both sticky flags
fifo_ovf_err  output  1  sticky: a beat arrived while the FIFO was full and was dropped
idle  output  1  FIFO empty and no beat arriving

Behaviour:
- Reset (rst=1 at clk edge):
  - FIFO count and pointers cleared to 0.
  - fflags_of, fflags_nv and fifo_ovf_err cleared to 0.
  - All handshake outputs derive from an empty FIFO: vrf_we=0, srf_we=0, sb_clr_valid=0, issue_stall=0, idle=1 (when alu_wb_valid=0).
  - Reset mid-drain discards all buffered entries without issuing writes.
- Push: push_ok = alu_wb_valid && (count<FIFO_DEPTH || pop). The entry {rd, is_scalar, data} is written at tail and the tail pointer wraps modulo FIFO_DEPTH.
- Overflow: alu_wb_valid && !push_ok drops the beat and sets fifo_ovf_err. fifo_ovf_err is cleared only by rst.
- Head output: driven combinationally from registered FIFO storage. There is no input-to-output bypass, so the minimum latency from alu_wb_valid to srf_we/vrf_we is 1 cycle.
  - Head is vector (is_scalar=0): vrf_we=1, vrf_waddr=rd, vrf_wdata=data.
  - Head is scalar: srf_we=1, srf_waddr=rd, srf_wdata=data[31:0].
  - Only one of vrf_we/srf_we is asserted per cycle, and neither when the FIFO is empty.
- Scalar x0: a head with is_scalar=1 and rd=0 pops in one cycle with srf_we=0 and sb_clr_valid=0.
- Pop happens on (vrf_we&&vrf_wready) || (srf_we&&srf_wready) || (x0 discard). The head pointer advances with wrap.
- While the RF ready is low, the head stays stable (write address and data held) and younger entries wait in order.
- Scoreboard clear: sb_clr_valid=1 in the same cycle as an accepted write, with sb_clr_idx=head rd and sb_clr_is_scalar=head is_scalar. It is a single-cycle pulse per entry.
- Count: count_next = count + push_ok - pop. Simultaneous push and pop when full is legal and count stays at FIFO_DEPTH.
- issue_stall = (count >= FIFO_DEPTH-1), combinational. This reserves one slot for the beat already in flight in the ALU, so a compliant issuer never triggers fifo_ovf_err.
- Sticky flags:
  - fflags_of is set on any cycle with alu_wb_valid && alu_wb_err_overflow; fflags_nv likewise with alu_wb_err_invalid.
  - Flags are set even if the beat is dropped.
  - When fflags_clr coincides with a set, the set wins (flag = 1 next cycle).
- idle = (count==0) && !alu_wb_valid.

Test Plan:
- Reset, then one vector beat rd=5, data=128'h1234 with vrf_wready=1 -> next cycle vrf_we=1, vrf_waddr=5, sb_clr_valid=1 with idx=5 and is_scalar=0; the following cycle idle=1.
- Scalar beat rd=3, data low word 32'hDEADBEEF, srf_wready held 0 for 3 cycles then 1 -> srf_we held 3+1 cycles with addr/data stable; exactly one sb_clr pulse on the accept cycle.
- 4 back-to-back beats (rd 1..4, alternating scalar/vector) with both readies 0 -> issue_stall asserts once count=3; all writes later drain in order 1,2,3,4; fifo_ovf_err=0.
- Full FIFO plus a 5th beat with readies 0 -> beat dropped, fifo_ovf_err=1, count stays 4. Repeat with vrf_wready=1 on the head in the same cycle -> beat accepted, count stays 4, no error.
- Scalar beat rd=0 -> no srf_we and no sb_clr; FIFO pops in 1 cycle.
- Beat with err_overflow=1 while fflags_clr=1 -> fflags_of=1 next cycle. fflags_clr alone -> both flags 0. rst asserted with 2 entries buffered -> count 0, no writes issued afterwards.
